// File: rtl/cla_adder_pipe_if.sv
// cla_adder_pipe_if: operand/result handshake bundle for cla_adder_pipe (out_zero/out_ovf present when CLA_ADDER_PIPE_FLAGS_EN is defined)
interface cla_adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef CLA_ADDER_PIPE_FLAGS_EN
    logic             out_zero;
    logic             out_ovf;
`endif

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
`ifdef CLA_ADDER_PIPE_FLAGS_EN
        output out_zero, out_ovf,
`endif
        output in_ready, out_valid, out_sum, out_cout
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
`ifdef CLA_ADDER_PIPE_FLAGS_EN
        input  out_zero, out_ovf,
`endif
        input  in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined carry-lookahead adder/subtractor, one BLK-bit lookahead block per stage; define CLA_ADDER_PIPE_FLAGS_EN for out_zero/out_ovf
module cla_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4
) (
    input logic             clk,
    input logic             rst,
    cla_adder_pipe_if.slave bus
);
    localparam int NSTG = (BLK < 1) ? 1 : WIDTH / BLK;

    if (BLK < 1 || (WIDTH % ((BLK < 1) ? 1 : BLK)) != 0) begin : g_bad_cfg
        $error("cla_adder_pipe: WIDTH must be a positive multiple of BLK");
    end

    function automatic logic [BLK:0] cla_carries(
        input logic [BLK-1:0] x,
        input logic [BLK-1:0] y,
        input logic           ci
    );
        logic [BLK-1:0] g;
        logic [BLK-1:0] p;
        logic [BLK:0]   cv;
        logic           t;
        g     = x & y;
        p     = x ^ y;
        cv    = '0;
        cv[0] = ci;
        for (int i = 0; i < BLK; i++) begin
            t = ci;
            for (int m = 0; m <= i; m++) t = t & p[m];
            cv[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) t = t & p[m];
                cv[i+1] = cv[i+1] | t;
            end
        end
        return cv;
    endfunction

    logic             adv;
    logic             v [NSTG];
    logic             c [NSTG];
    logic [WIDTH-1:0] s [NSTG];
    logic [WIDTH-1:0] a [NSTG];
    logic [WIDTH-1:0] b [NSTG];
`ifdef CLA_ADDER_PIPE_FLAGS_EN
    logic [WIDTH-1:0] last_sum;
    logic             last_cout;
    logic             last_cmsb;
    logic             zero_q;
    logic             ovf_q;
`endif

    assign adv          = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = adv;
    assign bus.out_valid = v[NSTG-1];
    assign bus.out_sum   = s[NSTG-1];
    assign bus.out_cout  = c[NSTG-1];

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic             pv;
        logic             pc;
        logic [WIDTH-1:0] pa;
        logic [WIDTH-1:0] pb;
        logic [WIDTH-1:0] ps;
        logic [WIDTH-1:0] ns;
        logic [BLK:0]     cv;
        if (k == 0) begin : g_src
            assign pv = bus.in_valid;
            assign pc = bus.in_sub | bus.in_cin;
            assign pa = bus.in_a;
            assign pb = bus.in_b ^ {WIDTH{bus.in_sub}};
            assign ps = '0;
        end else begin : g_src
            assign pv = v[k-1];
            assign pc = c[k-1];
            assign pa = a[k-1];
            assign pb = b[k-1];
            assign ps = s[k-1];
        end
        assign cv = cla_carries(pa[BLK*k +: BLK], pb[BLK*k +: BLK], pc);
        // insert this block's sum bits into the partial result passed down the pipe
        always_comb begin
            ns                = ps;
            ns[BLK*k +: BLK]  = pa[BLK*k +: BLK] ^ pb[BLK*k +: BLK] ^ cv[BLK-1:0];
        end
        // stage register: every stage moves together on advance, holds on stall
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v[k] <= 1'b0;
                c[k] <= 1'b0;
                s[k] <= '0;
                a[k] <= '0;
                b[k] <= '0;
            end else if (adv) begin
                v[k] <= pv;
                c[k] <= cv[BLK];
                s[k] <= ns;
                a[k] <= pa;
                b[k] <= pb;
            end
        end
`ifdef CLA_ADDER_PIPE_FLAGS_EN
        if (k == NSTG - 1) begin : g_last
            assign last_sum  = ns;
            assign last_cout = cv[BLK];
            assign last_cmsb = cv[BLK-1];
        end
`endif
    end

`ifdef CLA_ADDER_PIPE_FLAGS_EN
    // flags are captured with the final stage so they line up with out_sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            zero_q <= (last_sum == '0);
            ovf_q  <= last_cout ^ last_cmsb;
        end
    end

    assign bus.out_zero = zero_q;
    assign bus.out_ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: scoreboard bench for cla_adder_pipe (32/4 main instance, 4/4 single-stage instance)
module tb_cla_adder_pipe;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sb;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    localparam vec_t VT [12] = '{
        '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0},
        '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0},
        '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0},
        '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1},
        '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0},
        '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1},
        '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0},
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0},
        '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0},
        '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0},
        '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0},
        '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0}
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    logic [34:0] exp_q [$];
    logic [34:0] e_m;

    cla_adder_pipe_if #(.WIDTH(32)) bus ();
    cla_adder_pipe_if #(.WIDTH(4))  sbus ();

    cla_adder_pipe #(.WIDTH(32), .BLK(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    cla_adder_pipe #(.WIDTH(4),  .BLK(4)) dut4 (.clk(clk), .rst(rst), .bus(sbus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                            input logic ci, input logic sb);
        logic [31:0] yy;
        logic [32:0] r;
        yy = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {32'b0, sb | ci};
        return {(x[31] == yy[31]) && (r[31] != x[31]), r};
    endfunction

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic ci,
                        input logic sb, input logic [33:0] ex);
        int t;
        bus.in_a     = x;
        bus.in_b     = y;
        bus.in_cin   = ci;
        bus.in_sub   = sb;
        bus.in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (bus.in_ready) exp_q.push_back({ex[33], ex[31:0] == 32'h0, ex[32], ex[31:0]});
        else begin
            checks++;
            $display("FAIL accept_timeout: in_ready=%b, expected 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_vec(input int i);
        send(VT[i].a, VT[i].b, VT[i].ci, VT[i].sb, {VT[i].ov, VT[i].co, VT[i].s});
    endtask

    task automatic send_model(input int i);
        logic [31:0] x;
        logic [31:0] y;
        x = 32'h9E3779B9 * 32'(i + 1);
        y = {x[15:0], x[31:16]} ^ 32'h0F0FF0F0;
        send(x, y, i[0], i[1], ref_add(x, y, i[0], i[1]));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 0);
    endtask

    // monitor: every output transfer is compared against the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got sum %h cout %b, expected no result", bus.out_sum, bus.out_cout);
            end else begin
                e_m = exp_q.pop_front();
                chk("sum_cout", {bus.out_cout, bus.out_sum}, e_m[32:0]);
`ifdef CLA_ADDER_PIPE_FLAGS_EN
                chk("ovf_zero", {bus.out_ovf, bus.out_zero}, e_m[34:33]);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int start;
        logic [31:0] hold;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        sbus.in_valid  = 1'b0;
        sbus.in_a      = '0;
        sbus.in_b      = '0;
        sbus.in_cin    = 1'b0;
        sbus.in_sub    = 1'b0;
        sbus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_sum", bus.out_sum, 0);
        chk("reset_out_cout", bus.out_cout, 0);
`ifdef CLA_ADDER_PIPE_FLAGS_EN
        chk("reset_flags", {bus.out_ovf, bus.out_zero}, 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_vec(0);
        n = 0;
        repeat (7) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        chk("latency_early_valid", 64'(n), 0);
        @(negedge clk);
        chk("latency_valid_at_nstg", bus.out_valid, 1);
        @(posedge clk);
        #1;
        for (int i = 1; i < 12; i++) send_vec(i);
        drain();
        start = cyc;
        for (int i = 0; i < 40; i++) send_model(i);
        chk("stream_one_per_cycle", 64'(cyc - start), 40);
        drain();
        bus.out_ready = 1'b0;
        for (int i = 100; i < 108; i++) send_model(i);
        chk("stall_full_valid", bus.out_valid, 1);
        chk("stall_in_ready", bus.in_ready, 0);
        hold = bus.out_sum;
        chk("stall_head", hold, exp_q[0][31:0]);
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready_hold", bus.in_ready, 0);
            chk("stall_sum_stable", bus.out_sum, hold);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_model(108);
        drain();
        for (int i = 200; i < 203; i++) send_model(i);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_out_sum", bus.out_sum, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        chk("midrst_no_stale", 64'(n), 0);
        @(posedge clk);
        #1;
        send_vec(4);
        drain();
        sbus.in_a     = 4'h7;
        sbus.in_b     = 4'h1;
        sbus.in_valid = 1'b1;
        @(negedge clk);
        chk("w4_in_ready", sbus.in_ready, 1);
        @(posedge clk);
        #1;
        sbus.in_valid = 1'b0;
        @(negedge clk);
        chk("w4_out_valid", sbus.out_valid, 1);
        chk("w4_sum", sbus.out_sum, 4'h8);
        chk("w4_cout", sbus.out_cout, 0);
`ifdef CLA_ADDER_PIPE_FLAGS_EN
        chk("w4_ovf", sbus.out_ovf, 1);
`endif
        @(negedge clk);
        chk("w4_bubble", sbus.out_valid, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
